hit_manager: RTL



---
 rtl/hit_manager_pkg.sv | 16 +
 rtl/hit_manager_frame_end_detect.sv | 12 +
 rtl/hit_manager.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hit_manager_pkg.sv
// Shared definitions for the fight-phase hit logic: FSM encodings, screen limits
// and the game state code that enables hit detection.
package hit_manager_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_INVULN = 2'd2,
    ST_DEAD   = 2'd3
  } hm_state_t;

  localparam logic [9:0] SCREEN_LAST_X    = 10'd639;
  localparam logic [9:0] SCREEN_LAST_Y    = 10'd479;
  localparam int         FIGHT_STATE_CODE = 1;

endpackage

// File: rtl/hit_manager_frame_end_detect.sv
// Combinational frame-end flag: high on the last pixel of the visible frame.
module frame_end_detect
  import hit_manager_pkg::*;
(
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       fe
);

  assign fe = (x == SCREEN_LAST_X) && (y == SCREEN_LAST_Y);

endmodule

// File: rtl/hit_manager.sv
// Heart/bullet damage arbiter: accumulates overlaps per frame, resolves them at
// frame end, and runs the invulnerability blink window.
//
// state  | meaning
// IDLE   | not in the fight; overlaps are ignored
// ARMED  | fight active, next frame with an overlap costs DAMAGE
// INVULN | post-hit grace period of IFRAMES frames, heart blinks
// DEAD   | hp hit 0; held until reset
module hit_manager
  import hit_manager_pkg::*;
#(
  parameter int N_BULLETS   = 2,
  parameter int HP_MAX      = 20,
  parameter int DAMAGE      = 4,
  parameter int IFRAMES     = 30,
  parameter int FIGHT_STATE = FIGHT_STATE_CODE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           state,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 heartSpriteOn,
  input  logic [N_BULLETS-1:0] bulletSpriteOn,
  output logic [N_BULLETS-1:0] collision,
  output logic [7:0]           hp,
  output logic                 hit,
  output logic                 invuln,
  output logic                 heartVisible,
  output logic                 gameOver
);

  localparam logic [7:0] HP_INIT   = 8'(HP_MAX);
  localparam logic [7:0] DMG       = 8'(DAMAGE);
  localparam logic [7:0] CNT_START = 8'(IFRAMES - 1);

  hm_state_t            fsm;
  logic [N_BULLETS-1:0] pending;
  logic [7:0]           cnt;
  logic                 fe;
  logic                 fight;
  logic [N_BULLETS-1:0] pend_now;
  logic [7:0]           cnt_dec;

  frame_end_detect u_fe (
    .x  (x),
    .y  (y),
    .fe (fe)
  );

  assign fight    = (state == 4'(FIGHT_STATE));
  // The fe cycle's own overlap belongs to the frame being resolved.
  assign pend_now = pending | (heartSpriteOn ? bulletSpriteOn : '0);
  assign cnt_dec  = cnt - 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm          <= ST_IDLE;
      hp           <= HP_INIT;
      collision    <= '0;
      hit          <= 1'b0;
      invuln       <= 1'b0;
      heartVisible <= 1'b1;
      gameOver     <= 1'b0;
      pending      <= '0;
      cnt          <= 8'd0;
    end else begin
      collision <= '0;
      hit       <= 1'b0;
      pending   <= (fe || !fight) ? '0 : pend_now;

      case (fsm)
        ST_IDLE: begin
          heartVisible <= 1'b1;
          invuln       <= 1'b0;
          if (fight) fsm <= ST_ARMED;
        end

        ST_ARMED: begin
          if (!fight) begin
            fsm          <= ST_IDLE;
            cnt          <= 8'd0;
            heartVisible <= 1'b1;
          end else if (fe && (|pend_now)) begin
            collision <= pend_now;
            hit       <= 1'b1;
            if (hp > DMG) begin
              hp           <= hp - DMG;
              cnt          <= CNT_START;
              invuln       <= 1'b1;
              heartVisible <= ~CNT_START[2];
              fsm          <= ST_INVULN;
            end else begin
              hp       <= 8'd0;
              gameOver <= 1'b1;
              fsm      <= ST_DEAD;
            end
          end
        end

        ST_INVULN: begin
          if (!fight) begin
            fsm          <= ST_IDLE;
            cnt          <= 8'd0;
            invuln       <= 1'b0;
            heartVisible <= 1'b1;
          end else if (fe) begin
            if (cnt == 8'd0) begin
              fsm          <= ST_ARMED;
              invuln       <= 1'b0;
              heartVisible <= 1'b1;
            end else begin
              cnt          <= cnt_dec;
              heartVisible <= ~cnt_dec[2];
            end
          end
        end

        default: begin
          gameOver     <= 1'b1;
          invuln       <= 1'b0;
          heartVisible <= 1'b1;
        end
      endcase
    end
  end

endmodule
